// File: rtl/typedef_pkg.sv
// typedef_pkg: types and constants shared by the out-of-order backend blocks.
package typedef_pkg;
  localparam int RS_DEPTH = 8;
  localparam int TAG_W = 6;
  typedef struct packed {
    logic [5:0]       op;
    logic [TAG_W-1:0] rd;
    logic [15:0]      imm;
  } RS_ENTRY_t;
endpackage

// File: rtl/issue_queue_if.sv
// issue_queue_if: dispatch, wakeup and issue signals between the rename stage and one issue queue.
interface issue_queue_if import typedef_pkg::*; #(
  parameter int DEPTH = RS_DEPTH,
  parameter int PHY_WIDTH = 6
);
  logic                   flush;
  logic                   dispatch_valid;
  RS_ENTRY_t              dispatch_entry;
  logic [PHY_WIDTH-1:0]   dispatch_rs1_tag;
  logic [PHY_WIDTH-1:0]   dispatch_rs2_tag;
  logic                   dispatch_rs1_ready;
  logic                   dispatch_rs2_ready;
  logic                   dispatch_ready;
  logic                   wb0_valid;
  logic                   wb1_valid;
  logic [PHY_WIDTH-1:0]   wb0_tag;
  logic [PHY_WIDTH-1:0]   wb1_tag;
  logic                   issue_stall;
  logic                   issue_valid;
  RS_ENTRY_t              issue_instruction;
  logic [$clog2(DEPTH):0] rs_count;
  modport slave (
    input  flush, dispatch_valid, dispatch_entry, dispatch_rs1_tag, dispatch_rs2_tag,
           dispatch_rs1_ready, dispatch_rs2_ready, wb0_valid, wb1_valid, wb0_tag, wb1_tag,
           issue_stall,
    output dispatch_ready, issue_valid, issue_instruction, rs_count
  );
  modport master (
    output flush, dispatch_valid, dispatch_entry, dispatch_rs1_tag, dispatch_rs2_tag,
           dispatch_rs1_ready, dispatch_rs2_ready, wb0_valid, wb1_valid, wb0_tag, wb1_tag,
           issue_stall,
    input  dispatch_ready, issue_valid, issue_instruction, rs_count
  );
endinterface

// File: rtl/issue_queue_rs_select.sv
// rs_select: lowest-index-ready priority encoder for the collapsing issue queue.
module rs_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         req_i,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     found_o
);
  localparam int SW = $clog2(DEPTH);
  always_comb begin
    idx_o = '0;
    found_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = SW'(i);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_queue.sv
// issue_queue: collapsing reservation station; oldest-ready issue with two-port tag wakeup.
module issue_queue import typedef_pkg::*; #(
  parameter int DEPTH = RS_DEPTH,
  parameter int PHY_WIDTH = 6
) (
  input logic         clk,
  input logic         rst,
  issue_queue_if.slave io
);
  localparam int SW = $clog2(DEPTH);
  localparam int CW = SW + 1;
  typedef logic [PHY_WIDTH-1:0] tag_t;
  RS_ENTRY_t        entry_q [DEPTH];
  RS_ENTRY_t        entry_d [DEPTH];
  tag_t             t1_q [DEPTH];
  tag_t             t1_d [DEPTH];
  tag_t             t2_q [DEPTH];
  tag_t             t2_d [DEPTH];
  logic [DEPTH-1:0] r1_q, r1_d, r2_q, r2_d, v_q, v_d, r1_w, r2_w, sel_req, sh;
  logic [CW-1:0]    cnt_q, cnt_d, wpos;
  logic             iv_q;
  RS_ENTRY_t        ii_q;
  logic [SW-1:0]    sel_idx;
  logic             found, do_issue, accept;

  function automatic logic hit(input tag_t t);
    return (io.wb0_valid && io.wb0_tag == t) || (io.wb1_valid && io.wb1_tag == t);
  endfunction

  // Selection sees registered ready bits only; wakeups land in the next state.
  always_comb begin
    r1_w = '0;
    r2_w = '0;
    sel_req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      r1_w[i] = r1_q[i] | hit(t1_q[i]);
      r2_w[i] = r2_q[i] | hit(t2_q[i]);
      sel_req[i] = v_q[i] & r1_q[i] & r2_q[i];
    end
  end

  rs_select #(.DEPTH(DEPTH)) u_sel (.req_i(sel_req), .idx_o(sel_idx), .found_o(found));

  assign do_issue = found && !io.issue_stall;
  assign accept = io.dispatch_valid && io.dispatch_ready;
  assign wpos = cnt_q - CW'(do_issue);
  assign cnt_d = cnt_q + CW'(accept) - CW'(do_issue);

  // Entries at or above the issued slot slide down one; the top slot becomes empty.
  always_comb begin
    sh = '0;
    for (int i = 0; i < DEPTH; i++) sh[i] = do_issue && (i >= int'(sel_idx));
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = sh[i] ? entry_q[(i + 1) % DEPTH] : entry_q[i];
      t1_d[i] = sh[i] ? t1_q[(i + 1) % DEPTH] : t1_q[i];
      t2_d[i] = sh[i] ? t2_q[(i + 1) % DEPTH] : t2_q[i];
      r1_d[i] = sh[i] ? r1_w[(i + 1) % DEPTH] : r1_w[i];
      r2_d[i] = sh[i] ? r2_w[(i + 1) % DEPTH] : r2_w[i];
      v_d[i] = sh[i] ? (i < DEPTH - 1) && v_q[(i + 1) % DEPTH] : v_q[i];
    end
    if (accept) begin
      entry_d[wpos[SW-1:0]] = io.dispatch_entry;
      t1_d[wpos[SW-1:0]] = io.dispatch_rs1_tag;
      t2_d[wpos[SW-1:0]] = io.dispatch_rs2_tag;
      r1_d[wpos[SW-1:0]] = io.dispatch_rs1_ready | hit(io.dispatch_rs1_tag);
      r2_d[wpos[SW-1:0]] = io.dispatch_rs2_ready | hit(io.dispatch_rs2_tag);
      v_d[wpos[SW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      cnt_q <= '0;
      iv_q <= 1'b0;
      ii_q <= '0;
    end else if (io.flush) begin
      v_q <= '0;
      cnt_q <= '0;
      iv_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      v_q <= v_d;
      cnt_q <= cnt_d;
      iv_q <= do_issue;
      if (do_issue) ii_q <= entry_q[sel_idx];
    end
  end

  assign io.dispatch_ready = cnt_q < CW'(DEPTH);
  assign io.rs_count = cnt_q;
  assign io.issue_valid = iv_q;
  assign io.issue_instruction = ii_q;
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_issue_queue;
  import typedef_pkg::*;
  localparam int DEPTH = 8;
  typedef struct {
    RS_ENTRY_t e;
    logic [5:0] t1;
    logic [5:0] t2;
    bit r1;
    bit r2;
  } m_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  m_t q[$];
  bit m_iv = 1'b0;
  RS_ENTRY_t m_ii = '0;

  issue_queue_if #(.DEPTH(DEPTH), .PHY_WIDTH(6)) io();
  issue_queue #(.DEPTH(DEPTH), .PHY_WIDTH(6)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  function automatic RS_ENTRY_t mk(input int n);
    RS_ENTRY_t e;
    e.op = 6'(n);
    e.rd = 6'(n + 1);
    e.imm = 16'(n * 257 + 3);
    return e;
  endfunction

  function automatic bit whit(input logic [5:0] t);
    return (io.wb0_valid && io.wb0_tag == t) || (io.wb1_valid && io.wb1_tag == t);
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference: oldest fully-ready entry leaves; survivors and the new entry see this cycle's wakeups.
  task automatic model_edge();
    int f;
    bit acc;
    m_t n;
    if (rst) begin
      q.delete();
      m_iv = 1'b0;
      m_ii = '0;
    end else if (io.flush) begin
      q.delete();
      m_iv = 1'b0;
    end else begin
      f = -1;
      if (!io.issue_stall)
        for (int k = 0; k < q.size(); k++)
          if (f < 0 && q[k].r1 && q[k].r2) f = k;
      acc = io.dispatch_valid && q.size() < DEPTH;
      m_iv = f >= 0;
      if (f >= 0) begin
        m_ii = q[f].e;
        q.delete(f);
      end
      foreach (q[k]) begin
        q[k].r1 = q[k].r1 | whit(q[k].t1);
        q[k].r2 = q[k].r2 | whit(q[k].t2);
      end
      if (acc) begin
        n.e = io.dispatch_entry;
        n.t1 = io.dispatch_rs1_tag;
        n.t2 = io.dispatch_rs2_tag;
        n.r1 = io.dispatch_rs1_ready | whit(io.dispatch_rs1_tag);
        n.r2 = io.dispatch_rs2_ready | whit(io.dispatch_rs2_tag);
        q.push_back(n);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rs_count", 64'(io.rs_count), 64'(q.size()));
    chk("dispatch_ready", 64'(io.dispatch_ready), 64'(q.size() < DEPTH));
    chk("issue_valid", 64'(io.issue_valid), 64'(m_iv));
    chk("issue_instruction", 64'(io.issue_instruction), 64'(m_ii));
  endtask

  task automatic clr();
    io.flush = 1'b0;
    io.dispatch_valid = 1'b0;
    io.dispatch_entry = '0;
    io.dispatch_rs1_tag = '0;
    io.dispatch_rs2_tag = '0;
    io.dispatch_rs1_ready = 1'b0;
    io.dispatch_rs2_ready = 1'b0;
    io.wb0_valid = 1'b0;
    io.wb1_valid = 1'b0;
    io.wb0_tag = '0;
    io.wb1_tag = '0;
    io.issue_stall = 1'b0;
  endtask

  task automatic disp(input RS_ENTRY_t e, input int a, input int b, input bit ra, input bit rb);
    io.dispatch_valid = 1'b1;
    io.dispatch_entry = e;
    io.dispatch_rs1_tag = 6'(a);
    io.dispatch_rs2_tag = 6'(b);
    io.dispatch_rs1_ready = ra;
    io.dispatch_rs2_ready = rb;
  endtask

  initial begin
    logic [31:0] r;
    clr();
    step();
    step();
    rst = 1'b0;
    chk("reset_count", 64'(io.rs_count), 64'd0);
    chk("reset_dispatch_ready", 64'(io.dispatch_ready), 64'd1);
    chk("reset_issue_valid", 64'(io.issue_valid), 64'd0);
    chk("reset_issue_instruction", 64'(io.issue_instruction), 64'd0);
    // ready dispatch issues two edges later
    disp(mk(1), 1, 2, 1, 1);
    step();
    clr();
    chk("ready_not_yet", 64'(io.issue_valid), 64'd0);
    step();
    chk("ready_issue_valid", 64'(io.issue_valid), 64'd1);
    chk("ready_issue_payload", 64'(io.issue_instruction), 64'(mk(1)));
    chk("ready_count_zero", 64'(io.rs_count), 64'd0);
    // wakeup ordering: younger ready B overtakes A, A follows after its wakeup
    disp(mk(2), 5, 3, 0, 1);
    step();
    disp(mk(3), 7, 8, 1, 1);
    step();
    clr();
    io.wb0_valid = 1'b1;
    io.wb0_tag = 6'd5;
    step();
    clr();
    chk("order_b_first", 64'(io.issue_instruction), 64'(mk(3)));
    step();
    chk("order_a_valid", 64'(io.issue_valid), 64'd1);
    chk("order_a_second", 64'(io.issue_instruction), 64'(mk(2)));
    // full boundary
    for (int k = 0; k < 8; k++) begin
      disp(mk(10 + k), 40, 0, 0, 1);
      step();
    end
    chk("full_count", 64'(io.rs_count), 64'd8);
    chk("full_not_ready", 64'(io.dispatch_ready), 64'd0);
    disp(mk(30), 1, 1, 1, 1);
    step();
    chk("full_drop_count", 64'(io.rs_count), 64'd8);
    clr();
    io.flush = 1'b1;
    step();
    clr();
    chk("full_flush_count", 64'(io.rs_count), 64'd0);
    // issue and dispatch in the same cycle at count 3
    io.issue_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      disp(mk(50 + k), 1, 1, 1, 1);
      step();
    end
    io.issue_stall = 1'b0;
    disp(mk(53), 1, 1, 1, 1);
    step();
    clr();
    chk("simul_count", 64'(io.rs_count), 64'd3);
    chk("simul_first", 64'(io.issue_instruction), 64'(mk(50)));
    for (int k = 1; k < 4; k++) begin
      step();
      chk("simul_order", 64'(io.issue_instruction), 64'(mk(50 + k)));
    end
    chk("simul_drained", 64'(io.rs_count), 64'd0);
    // wakeup in the dispatch cycle
    disp(mk(60), 12, 3, 0, 1);
    io.wb1_valid = 1'b1;
    io.wb1_tag = 6'd12;
    step();
    clr();
    step();
    chk("disp_wake_valid", 64'(io.issue_valid), 64'd1);
    chk("disp_wake_payload", 64'(io.issue_instruction), 64'(mk(60)));
    // flush with four entries, then a three-cycle stall
    io.issue_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      disp(mk(64 + k), 2, 2, 1, 1);
      step();
    end
    chk("flush_pre_count", 64'(io.rs_count), 64'd4);
    clr();
    io.flush = 1'b1;
    step();
    clr();
    chk("flush_count", 64'(io.rs_count), 64'd0);
    chk("flush_issue_valid", 64'(io.issue_valid), 64'd0);
    io.issue_stall = 1'b1;
    disp(mk(70), 2, 2, 1, 1);
    step();
    clr();
    io.issue_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_no_issue", 64'(io.issue_valid), 64'd0);
      step();
    end
    chk("stall_still_held", 64'(io.issue_valid), 64'd0);
    io.issue_stall = 1'b0;
    step();
    chk("stall_release_valid", 64'(io.issue_valid), 64'd1);
    chk("stall_release_payload", 64'(io.issue_instruction), 64'(mk(70)));
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      io.flush = $urandom_range(0, 79) == 0;
      io.dispatch_valid = $urandom_range(0, 2) != 0;
      r = $urandom;
      io.dispatch_entry = r[$bits(RS_ENTRY_t)-1:0];
      io.dispatch_rs1_tag = 6'($urandom_range(0, 15));
      io.dispatch_rs2_tag = 6'($urandom_range(0, 15));
      io.dispatch_rs1_ready = $urandom_range(0, 2) == 0;
      io.dispatch_rs2_ready = $urandom_range(0, 1) == 0;
      io.wb0_valid = $urandom_range(0, 1) == 0;
      io.wb1_valid = $urandom_range(0, 2) == 0;
      io.wb0_tag = 6'($urandom_range(0, 15));
      io.wb1_tag = $urandom_range(0, 3) == 0 ? io.wb0_tag : 6'($urandom_range(0, 15));
      io.issue_stall = $urandom_range(0, 3) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
